map_history_buffer: RTL
=======================

MAP_HISTORY_BUFFER -- requirements
Module: map_history_buffer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port CLK, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port nRST, input, 1 bit: asynchronous reset, asserted when 1 (active-high; the name follows the codebase port naming).
REQ-004 SHALL have ports disp_valid (in, 1), disp_arch_reg_tag (in, arch_reg_tag_t), disp_old_phys_reg_tag (in, phys_reg_tag_t) and disp_new_phys_reg_tag (in, phys_reg_tag_t): one new rename mapping per dispatch.
REQ-005 SHALL have ports disp_ready (out, 1), meaning the entry is accepted, and disp_index (out, mhb_index_t), the entry slot the mapping is written to (the tail).
REQ-006 SHALL have ports commit_valid (in, 1), free_valid (out, 1) and free_phys_reg_tag (out, phys_reg_tag_t): in-order retire of the head entry, releasing its old physical register.
REQ-007 SHALL have ports squash_valid (in, 1) and squash_index (in, mhb_index_t): the oldest entry to undo.
REQ-008 SHALL have ports kill_map_valid (out, 1), kill_map_dest_arch_reg_tag (out, arch_reg_tag_t), kill_map_old_dest_phys_reg_tag (out, phys_reg_tag_t) and kill_map_new_dest_phys_reg_tag (out, phys_reg_tag_t): the undo stream to the map table.
REQ-009 SHALL have port busy (out, 1): high while in RESTORE.

Function
REQ-010 SHALL hold 16 entries of {arch, old_phys, new_phys}, addressed by 5-bit head and tail pointers (4-bit index plus 1 wrap bit).
- full: the index bits are equal and the wrap bits differ.
- empty: the pointers are equal.
REQ-011 SHALL implement two states, IDLE and RESTORE.
REQ-012 SHALL drive disp_ready = IDLE & ~full & ~squash_valid, combinationally.
- A dispatch in the same cycle as a commit on a full buffer is still refused.
REQ-013 SHALL, on disp_valid & disp_ready, write the entry at the tail and increment the tail at the edge, wrapping 15 -> 0 and toggling the wrap bit.
REQ-014 SHALL drive free_valid = commit_valid & ~empty & (IDLE | head != stop).
- free_phys_reg_tag is the head entry's old_phys, combinational.
- When free_valid is high, the head increments at the edge.
REQ-015 SHALL, in IDLE on squash_valid with squash_index in [head, tail):
- latch stop = squash_index;
- go to RESTORE at the next edge.
REQ-016 SHALL treat a squash_index equal to the tail's index, or outside [head, tail), as a no-op that stays in IDLE.
REQ-017 SHALL, in RESTORE each cycle:
- assert kill_map_valid with the fields of entry tail-1, youngest first, one entry per cycle;
- decrement the tail at the edge;
- move to IDLE when tail-1 == stop.
REQ-018 SHALL give latency as follows: squash accepted at cycle N -> first kill at N+1; undoing K entries -> busy for cycles N+1..N+K and IDLE at N+K+1.
REQ-019 SHALL, on squash_valid during RESTORE with an index in [head, stop), update stop to that older index; otherwise the squash is ignored.
REQ-020 SHALL allow commits during RESTORE only while head != stop.
REQ-021 SHALL hold kill_map_valid at 0 in IDLE, and set the kill data outputs to don't-care when kill_map_valid is 0.

Reset
REQ-022 SHALL, on nRST=1 asynchronously:
- head=0, tail=0, stop=0, state IDLE;
- busy=0, kill_map_valid=0, free_valid=0, disp_ready=1, disp_index=0.
REQ-023 SHALL abort any RESTORE in progress on reset; entry storage need not be cleared.

Structure
REQ-024 SHALL take arch_reg_tag_t (5 bits) and phys_reg_tag_t (6 bits) from instr_types_pkg, and SHALL add mhb_index_t (4 bits) and MHB_DEPTH=16 there.
REQ-025 SHALL be a single module with no sub-modules; storage is a flop array with combinational read at head and tail-1.

Verification
REQ-026 Reset then dispatch {r3,p3,p40} -> disp_index=0, then 1 for the next dispatch; commit -> free_valid=1, free_phys_reg_tag=p3.
REQ-027 Dispatch 16 entries -> disp_ready=0; a further dispatch with a simultaneous commit is refused; next cycle disp_ready=1, and a dispatch is accepted at index 0 with the wrap bit toggled.
REQ-028 Dispatch indices 0..4 (new p40..p44), squash_index=2 -> kills at N+1..N+3 carry new p44, p43, p42, and busy drops at N+4; a following dispatch gets disp_index=2.
REQ-029 During RESTORE (stop=3, tail at 6) squash_index=1 -> the walk continues down through index 1 (5 kills total); squash_index=5 in the same situation is ignored.
REQ-030 Squash with tail wrapped (head=14, tail=2, squash_index=15) -> kills for indices 1, 0, 15 in order, and the final tail index is 15.
REQ-031 Assert nRST mid-RESTORE -> kill_map_valid=0 immediately, and busy=0 with empty=1 afterwards.

Source files
------------

// File: rtl/instr_types_pkg.sv
// ============================================================================
// Module      : instr_types_pkg
// Description : Shared rename/dispatch types and map-history-buffer sizing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package instr_types_pkg;

  typedef logic [4:0] arch_reg_tag_t;
  typedef logic [5:0] phys_reg_tag_t;

  localparam int MHB_DEPTH = 16;
  typedef logic [3:0] mhb_index_t;

  // Pointer = {wrap bit, index}
  typedef logic [4:0] mhb_ptr_t;

  typedef struct packed {
    arch_reg_tag_t arch;
    phys_reg_tag_t old_phys;
    phys_reg_tag_t new_phys;
  } mhb_entry_t;

  typedef logic [0:0] mhb_state_t;
  localparam mhb_state_t MHB_IDLE    = 1'b0;
  localparam mhb_state_t MHB_RESTORE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/map_history_buffer.sv
// ============================================================================
// Module      : map_history_buffer
// Description : 16-entry rename history FIFO; retires old mappings in order
//               and walks back youngest-first to undo a squash.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module map_history_buffer
  import instr_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  input  logic          disp_valid,
  input  arch_reg_tag_t disp_arch_reg_tag,
  input  phys_reg_tag_t disp_old_phys_reg_tag,
  input  phys_reg_tag_t disp_new_phys_reg_tag,
  output logic          disp_ready,
  output mhb_index_t    disp_index,
  input  logic          commit_valid,
  output logic          free_valid,
  output phys_reg_tag_t free_phys_reg_tag,
  input  logic          squash_valid,
  input  mhb_index_t    squash_index,
  output logic          kill_map_valid,
  output arch_reg_tag_t kill_map_dest_arch_reg_tag,
  output phys_reg_tag_t kill_map_old_dest_phys_reg_tag,
  output phys_reg_tag_t kill_map_new_dest_phys_reg_tag,
  output logic          busy
);

  mhb_entry_t entries_q [MHB_DEPTH];

  mhb_ptr_t   head_q, head_d;
  mhb_ptr_t   tail_q, tail_d;
  mhb_index_t stop_q, stop_d;
  mhb_state_t state_q, state_d;

  logic       is_idle;
  logic       full, empty;
  mhb_index_t head_idx, tail_idx, tail_m1_idx;
  mhb_index_t sq_off, stop_off;
  mhb_ptr_t   occupancy;
  logic       sq_accept_idle, sq_accept_restore;
  logic       kill_last;
  logic       disp_fire;

  assign head_idx    = head_q[3:0];
  assign tail_idx    = tail_q[3:0];
  assign tail_m1_idx = tail_idx - 4'd1;
  assign full        = (head_idx == tail_idx) && (head_q[4] != tail_q[4]);
  assign empty       = (head_q == tail_q);

  // Window tests are done as offsets from head so they survive index wrap.
  assign sq_off    = squash_index - head_idx;
  assign stop_off  = stop_q - head_idx;
  assign occupancy = tail_q - head_q;

  assign sq_accept_idle    = is_idle && squash_valid &&
                             ({1'b0, sq_off} < occupancy) && (squash_index != tail_idx);
  assign sq_accept_restore = !is_idle && squash_valid && (sq_off < stop_off);
  assign kill_last         = (tail_m1_idx == stop_q);
  assign disp_fire         = disp_valid && disp_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) state_q <= MHB_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      MHB_IDLE:    if (sq_accept_idle) state_d = MHB_RESTORE;
      MHB_RESTORE: if (kill_last && !sq_accept_restore) state_d = MHB_IDLE;
      default:     state_d = MHB_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    is_idle        = (state_q == MHB_IDLE);
    busy           = (state_q == MHB_RESTORE);
    kill_map_valid = (state_q == MHB_RESTORE);
    disp_ready     = is_idle && !full && !squash_valid;
    free_valid     = commit_valid && !empty && (is_idle || (head_idx != stop_q));
  end

  assign disp_index                     = tail_idx;
  assign free_phys_reg_tag              = entries_q[head_idx].old_phys;
  assign kill_map_dest_arch_reg_tag     = entries_q[tail_m1_idx].arch;
  assign kill_map_old_dest_phys_reg_tag = entries_q[tail_m1_idx].old_phys;
  assign kill_map_new_dest_phys_reg_tag = entries_q[tail_m1_idx].new_phys;

  // ---------------- Pointer next-state ----------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    stop_d = stop_q;
    if (free_valid) head_d = head_q + 5'd1;
    if (busy)           tail_d = tail_q - 5'd1;
    else if (disp_fire) tail_d = tail_q + 5'd1;
    if (sq_accept_idle || sq_accept_restore) stop_d = squash_index;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      head_q <= '0;
      tail_q <= '0;
      stop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      stop_q <= stop_d;
    end
  end

  // Storage carries no reset; stale entries are never read as valid.
  always_ff @(posedge CLK) begin
    if (disp_fire) begin
      entries_q[tail_idx] <= '{arch:     disp_arch_reg_tag,
                               old_phys: disp_old_phys_reg_tag,
                               new_phys: disp_new_phys_reg_tag};
    end
  end

endmodule

`default_nettype wire
